// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy, almost-full/empty thresholds and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads have one cycle of latency.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          din,
    input  logic                       pop,
    output logic [DATA_W-1:0]          dout,
    output logic                       dout_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clear_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [LW-1:0] LVL_ONE = LW'(1);
    localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);
    localparam logic [LW-1:0] AF_THR  = LW'(AF_LEVEL);
    localparam logic [LW-1:0] AE_THR  = LW'(AE_LEVEL);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [LW-1:0]     level_r;
    logic              overflow_r;
    logic              underflow_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    // Status flags decode straight from the registered occupancy.
    always_comb begin
        full         = (level_r == LVL_MAX);
        empty        = (level_r == {LW{1'b0}});
        almost_full  = (level_r >= AF_THR);
        almost_empty = (level_r <= AE_THR);
        level        = level_r;
        overflow     = overflow_r;
        underflow    = underflow_r;
        push_ok_s    = push && !full;
        pop_ok_s     = pop && !empty;
    end

    // Storage array; contents are never cleared, only the pointers are.
    always_ff @(posedge clk) begin
        if (!reset && push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Sticky error flags; a new offence wins over clear_err in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (push && full) begin
                overflow_r <= 1'b1;
            end else if (clear_err) begin
                overflow_r <= 1'b0;
            end
            if (pop && empty) begin
                underflow_r <= 1'b1;
            end else if (clear_err) begin
                underflow_r <= 1'b0;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    // Head of queue is always presented; it goes stale but stable once empty.
    always_comb begin
        dout       = mem_r[rd_ptr_r];
        dout_valid = !empty;
    end
`else
    logic [DATA_W-1:0] dout_r;
    logic              dout_valid_r;

    // Registered read port: dout holds the last popped word between pops.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_r       <= {DATA_W{1'b0}};
            dout_valid_r <= 1'b0;
        end else begin
            dout_valid_r <= pop_ok_s;
            if (pop_ok_s) begin
                dout_r <= mem_r[rd_ptr_r];
            end
        end
    end

    // Drive the read outputs from their registers.
    always_comb begin
        dout       = dout_r;
        dout_valid = dout_valid_r;
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed scenarios plus randomized traffic against a queue model.
// Follows FIFO_FWFT_EN when it is defined for the build.
module tb_sync_fifo_param;
    localparam int DW = 8;
    localparam int D  = 8;
    localparam int AF = 6;
    localparam int AE = 2;

    logic          clk = 1'b0;
    logic          reset, push, pop, clear_err;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0]    level;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: a plain queue plus the last popped word and sticky flags.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    bit            m_valid, m_ovf, m_unf;

    sync_fifo_param #(.DATA_W(DW), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .reset(reset), .push(push), .din(din), .pop(pop),
        .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
        .overflow(overflow), .underflow(underflow), .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] exp_dout();
`ifdef FIFO_FWFT_EN
        return (q.size() != 0) ? q[0] : m_dout;
`else
        return m_dout;
`endif
    endfunction

    function automatic bit exp_valid();
`ifdef FIFO_FWFT_EN
        return q.size() != 0;
`else
        return m_valid;
`endif
    endfunction

    // One clock of stimulus, applied at a falling edge; the model advances at the rising edge.
    task automatic drive(input bit p, input logic [DW-1:0] d, input bit po, input bit c, input bit r);
        bit f, e;
        push = p; din = d; pop = po; clear_err = c; reset = r;
        @(posedge clk);
        f = (q.size() == D);
        e = (q.size() == 0);
        if (r) begin
            q.delete();
            m_dout = '0; m_valid = 0; m_ovf = 0; m_unf = 0;
        end else begin
            m_valid = 0;
            if (po && !e) begin
                m_dout  = q.pop_front();
                m_valid = 1;
            end
            if (p && !f) q.push_back(d);
            if (p && f) m_ovf = 1; else if (c) m_ovf = 0;
            if (po && e) m_unf = 1; else if (c) m_unf = 0;
        end
        @(negedge clk);
        push = 0; pop = 0; clear_err = 0; reset = 0;
    endtask

    task automatic test_reset();
        drive(0, '0, 0, 0, 1);
        drive(0, '0, 0, 0, 1);
        tests_run++; if (level !== 4'd0) begin tests_failed++; $display("FAIL reset_level got %0d want 0", level); end
        tests_run++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin
            tests_failed++; $display("FAIL reset_flags got e%b f%b ae%b af%b want e1 f0 ae1 af0", empty, full, almost_empty, almost_full);
        end
        tests_run++; if ({overflow, underflow, dout_valid} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_err got ovf%b unf%b vld%b want 000", overflow, underflow, dout_valid);
        end
`ifndef FIFO_FWFT_EN
        tests_run++; if (dout !== 8'h00) begin tests_failed++; $display("FAIL reset_dout got %h want 00", dout); end
`endif
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= D; i++) begin
            drive(1, 8'(i), 0, 0, 0);
            tests_run++; if (level !== 4'(i)) begin tests_failed++; $display("FAIL fill_level got %0d want %0d", level, i); end
            tests_run++; if (almost_full !== (i >= AF) || full !== (i == D)) begin
                tests_failed++; $display("FAIL fill_flags lvl %0d got af%b f%b want af%b f%b", i, almost_full, full, i >= AF, i == D);
            end
        end
        for (int i = 1; i <= D; i++) begin
`ifdef FIFO_FWFT_EN
            tests_run++; if (dout_valid !== 1'b1 || dout !== 8'(i)) begin
                tests_failed++; $display("FAIL drain_head got %h/%b want %h/1", dout, dout_valid, 8'(i));
            end
`endif
            drive(0, '0, 1, 0, 0);
`ifndef FIFO_FWFT_EN
            tests_run++; if (dout_valid !== 1'b1 || dout !== 8'(i)) begin
                tests_failed++; $display("FAIL drain_data got %h/%b want %h/1", dout, dout_valid, 8'(i));
            end
`endif
        end
        tests_run++; if (empty !== 1'b1 || level !== 4'd0) begin tests_failed++; $display("FAIL drain_empty got e%b lvl %0d want e1 lvl 0", empty, level); end
    endtask

    task automatic test_underflow();
        drive(0, '0, 1, 0, 0);
        tests_run++; if (underflow !== 1'b1 || dout_valid !== 1'b0) begin
            tests_failed++; $display("FAIL unf_set got unf%b vld%b want unf1 vld0", underflow, dout_valid);
        end
`ifndef FIFO_FWFT_EN
        tests_run++; if (dout !== exp_dout()) begin tests_failed++; $display("FAIL unf_dout got %h want %h", dout, exp_dout()); end
`endif
        drive(0, '0, 1, 1, 0);
        tests_run++; if (underflow !== 1'b1) begin tests_failed++; $display("FAIL unf_priority got %b want 1", underflow); end
        drive(0, '0, 0, 1, 0);
        tests_run++; if (underflow !== 1'b0) begin tests_failed++; $display("FAIL unf_clear got %b want 0", underflow); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < D; i++) drive(1, 8'($urandom), 0, 0, 0);
        drive(1, 8'hAA, 0, 0, 0);
        tests_run++; if (overflow !== 1'b1 || level !== 4'd8) begin
            tests_failed++; $display("FAIL ovf_set got ovf%b lvl %0d want ovf1 lvl 8", overflow, level);
        end
        drive(0, '0, 0, 1, 0);
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear got %b want 0", overflow); end
        drive(1, 8'h55, 1, 0, 0);
        tests_run++; if (level !== 4'd7 || overflow !== 1'b1 || dout !== exp_dout() || dout_valid !== exp_valid()) begin
            tests_failed++; $display("FAIL full_pushpop got lvl %0d ovf%b d %h want lvl 7 ovf1 d %h", level, overflow, dout, exp_dout());
        end
        for (int i = 0; i < 7; i++) drive(0, '0, 1, 1, 0);
        drive(1, 8'h77, 1, 0, 0);
        tests_run++; if (level !== 4'd1 || underflow !== 1'b1 || overflow !== 1'b0) begin
            tests_failed++; $display("FAIL empty_pushpop got lvl %0d unf%b ovf%b want lvl 1 unf1 ovf0", level, underflow, overflow);
        end
        drive(0, '0, 1, 1, 0);
    endtask

    task automatic test_wrap();
        drive(0, '0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(1, 8'($urandom), 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            drive(1, 8'($urandom), 1, 0, 0);
            tests_run++; if (level !== 4'd3 || dout_valid !== exp_valid() || dout !== exp_dout()) begin
                tests_failed++; $display("FAIL wrap cyc %0d got lvl %0d d %h v%b want lvl 3 d %h v%b", i, level, dout, dout_valid, exp_dout(), exp_valid());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45),
                  1'($urandom_range(0, 99) < 10), 1'($urandom_range(0, 99) < 2));
            tests_run++; if (level !== 4'(q.size())) begin tests_failed++; $display("FAIL rnd_level cyc %0d got %0d want %0d", i, level, q.size()); end
            tests_run++; if ({empty, full, almost_empty, almost_full} !== {q.size() == 0, q.size() == D, q.size() <= AE, q.size() >= AF}) begin
                tests_failed++; $display("FAIL rnd_flags cyc %0d got %b lvl %0d", i, {empty, full, almost_empty, almost_full}, q.size());
            end
            tests_run++; if (overflow !== m_ovf || underflow !== m_unf) begin
                tests_failed++; $display("FAIL rnd_err cyc %0d got %b%b want %b%b", i, overflow, underflow, m_ovf, m_unf);
            end
            tests_run++; if (dout_valid !== exp_valid() || (exp_valid() && dout !== exp_dout())) begin
                tests_failed++; $display("FAIL rnd_data cyc %0d got %h/%b want %h/%b", i, dout, dout_valid, exp_dout(), exp_valid());
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(0, '0, 0, 0, 1);
        for (int i = 0; i < 5; i++) drive(1, 8'($urandom), 0, 0, 0);
        drive(1, 8'h11, 1, 0, 1);
        tests_run++; if (level !== 4'd0 || empty !== 1'b1 || dout_valid !== 1'b0) begin
            tests_failed++; $display("FAIL midreset got lvl %0d e%b v%b want lvl 0 e1 v0", level, empty, dout_valid);
        end
`ifndef FIFO_FWFT_EN
        tests_run++; if (dout !== 8'h00) begin tests_failed++; $display("FAIL midreset_dout got %h want 00", dout); end
`endif
        drive(1, 8'h3C, 0, 0, 0);
        tests_run++; if (dout_valid !== exp_valid() || (exp_valid() && dout !== 8'h3C)) begin
            tests_failed++; $display("FAIL push_after_reset got %h/%b want %h/%b", dout, dout_valid, 8'h3C, exp_valid());
        end
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; clear_err = 1'b0; din = '0;
        m_dout = '0; m_valid = 0; m_ovf = 0; m_unf = 0;
        @(negedge clk);
        test_reset();
        test_fill_drain();
        test_underflow();
        test_overflow();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
